sync_hs_rx: RTL

Receive end of the four-phase req/ack handshake used to carry a control word from a faster clock domain into the slow domain. It synchronizes the incoming level request and captures the data bus once the request is stable. It acknowledges the source and presents the word on a local valid/ready interface with a one-entry buffer. It sits entirely in the slow domain, opposite the transmit-side holder that keeps `req_i`/`data_i` stable until `ack_o` is seen.

---
 rtl/sync_pkg.sv | 12 +
 rtl/sync_dff_chain.sv | 28 ++
 rtl/sync_hs_rx.sv | 87 ++++++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for both ends of the four-phase req/ack control-word crossing.
// State encoding is fixed so transmit and receive sides agree on what ack means.
package sync_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } hs_state_t;

   localparam int SYNC_STG_MIN = 2;

endpackage : sync_pkg

// File: rtl/sync_dff_chain.sv
// Multi-flop synchronizer for a level signal; output lags input by DEPTH edges.
// No flow control: it samples every edge and clears synchronously on reset.
module sync_dff_chain
   import sync_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = SYNC_STG_MIN
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_s[i] <= '0;
      end else begin
         r_s[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_s[i] <= r_s[i-1];
      end
   end

   assign o_q = r_s[DEPTH-1];

endmodule : sync_dff_chain

// File: rtl/sync_hs_rx.sv
// Receive side of a four-phase req/ack crossing: capture latency SYNC_STG+1 edges.
// A full one-entry buffer withholds ack, so the source stalls until the consumer drains.
module sync_hs_rx
   import sync_pkg::*;
#(
   parameter int DW       = 8,
   parameter int SYNC_STG = 2,
   parameter int CW       = 16
) (
   input  logic          clk_s,
   input  logic          rst_s,
   input  logic          req_i,
   input  logic [DW-1:0] data_i,
   output logic          ack_o,
   output logic [DW-1:0] data_o,
   output logic          vld_o,
   input  logic          rdy_i,
   output logic [CW-1:0] cnt_o
);

   hs_state_t     r_state;
   hs_state_t     w_state_nxt;
   logic          w_req_sy;
   logic          w_buf_free;
   logic          w_cap;
   logic          r_vld;
   logic [DW-1:0] r_data;
   logic [CW-1:0] r_cnt;

   sync_dff_chain #(
      .W     (1),
      .DEPTH (SYNC_STG)
   ) u_req_sync (
      .i_clk (clk_s),
      .i_rst (rst_s),
      .i_d   (req_i),
      .o_q   (w_req_sy)
   );

   // Draining and refilling in the same edge keeps the stream bubble-free.
   assign w_buf_free = !r_vld || rdy_i;

   always_ff @(posedge clk_s) begin
      if (rst_s) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_sy && w_buf_free) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!w_req_sy) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_s) begin
      if (rst_s) begin
         r_vld  <= 1'b0;
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_cap) begin
            r_vld  <= 1'b1;
            r_data <= data_i;
            r_cnt  <= r_cnt + 1'b1;
         end else if (r_vld && rdy_i) begin
            r_vld  <= 1'b0;
         end
      end
   end

   // State is itself a flop, so ack is glitch-free toward the source domain.
   assign ack_o  = (r_state == ST_ACK);
   assign vld_o  = r_vld;
   assign data_o = r_data;
   assign cnt_o  = r_cnt;

endmodule : sync_hs_rx
